// File: rtl/rosc_entropy_collector.sv
// rosc_entropy_collector
//   Consumer side of the ring-oscillator entropy sources. It drives fixed
//   operands into the oscillator array and brings the raw dout bits into the
//   clk domain through a two-flop synchronizer. Every SAMPLE_CYCLES it samples
//   the XOR-fold of the synchronized bits and packs the samples into
//   DATA_WIDTH-bit words. Each word is handed downstream over a valid/ack
//   handshake.
//
//   Ports:
//     clk           system clock
//     reset         synchronous, active-high reset
//     enable        collection enable
//     rosc_dout     raw oscillator outputs, asynchronous to clk
//     op_a, op_b    operands to all oscillators (0xAA.. and its complement)
//     entropy_data  collected word, stable while entropy_valid=1
//     entropy_valid entropy_data holds a complete word
//     entropy_ack   consumer accepts the word
//
//   Build option: define ROSC_VN_DEBIAS_EN to enable von Neumann debiasing.
//   Samples are then consumed in pairs, and only unequal pairs contribute a
//   bit.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | counters and shift register held at 0, wait for enable
//   COLLECT | sampling every SAMPLE_CYCLES, shifting bits into word
//   FULL    | word presented, sampling frozen until ack

module rosc_entropy_collector #(
    parameter int NUM_ROSC      = 32,
    parameter int OP_WIDTH      = 8,
    parameter int SAMPLE_CYCLES = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_ROSC-1:0]   rosc_dout,
    output logic [OP_WIDTH-1:0]   op_a,
    output logic [OP_WIDTH-1:0]   op_b,
    output logic [DATA_WIDTH-1:0] entropy_data,
    output logic                  entropy_valid,
    input  logic                  entropy_ack
);

    localparam int CTR_W = $clog2(SAMPLE_CYCLES);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CTR_W-1:0] LAST_SAMPLE = CTR_W'(SAMPLE_CYCLES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_WIDTH - 1);

    // 0xAA.. pattern: odd bit positions set, LSB clear.
    function automatic logic [OP_WIDTH-1:0] alt_pattern();
        logic [OP_WIDTH-1:0] p;
        for (int i = 0; i < OP_WIDTH; i++) begin
            p[i] = ((i % 2) == 1);
        end
        return p;
    endfunction

    localparam logic [OP_WIDTH-1:0] OP_A_INIT = alt_pattern();

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FULL
    } state_t;

    state_t                state_q;
    logic [CTR_W-1:0]      sample_ctr_q;
    logic [CTR_W-1:0]      sample_ctr_d;
    logic [BIT_W-1:0]      bit_ctr_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic [OP_WIDTH-1:0]   op_a_q;
    logic [OP_WIDTH-1:0]   op_b_q;
    logic [NUM_ROSC-1:0]   sync1_q;
    logic [NUM_ROSC-1:0]   sync2_q;

    logic sample_bit;
    logic sample_tick;
    logic take_bit;
    logic take_val;

    assign sample_bit   = ^sync2_q;
    assign sample_tick  = (state_q == ST_COLLECT) && (sample_ctr_q == LAST_SAMPLE);
    assign sample_ctr_d = (sample_ctr_q == LAST_SAMPLE) ? '0 : sample_ctr_q + CTR_W'(1);

`ifdef ROSC_VN_DEBIAS_EN
    logic pair_q;   // 1 = the first sample of a pair is held in first_q
    logic first_q;

    // Only an unequal pair produces a bit, and that bit is the first sample.
    assign take_bit = sample_tick && pair_q && (first_q != sample_bit);
    assign take_val = first_q;
`else
    assign take_bit = sample_tick;
    assign take_val = sample_bit;
`endif

    assign shift_d = {shift_q[DATA_WIDTH-2:0], take_val};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sample_ctr_q <= '0;
            bit_ctr_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            op_a_q       <= OP_A_INIT;
            op_b_q       <= ~OP_A_INIT;
`ifdef ROSC_VN_DEBIAS_EN
            pair_q       <= 1'b0;
            first_q      <= 1'b0;
`endif
        end else begin
            sync1_q <= rosc_dout;
            sync2_q <= sync1_q;

            case (state_q)
                ST_IDLE: begin
                    sample_ctr_q <= '0;
                    bit_ctr_q    <= '0;
                    shift_q      <= '0;
`ifdef ROSC_VN_DEBIAS_EN
                    pair_q       <= 1'b0;
`endif
                    if (enable) begin
                        state_q <= ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (!enable) begin
                        state_q      <= ST_IDLE;
                        sample_ctr_q <= '0;
                        bit_ctr_q    <= '0;
                        shift_q      <= '0;
`ifdef ROSC_VN_DEBIAS_EN
                        pair_q       <= 1'b0;
`endif
                    end else begin
                        sample_ctr_q <= sample_ctr_d;
`ifdef ROSC_VN_DEBIAS_EN
                        if (sample_tick) begin
                            pair_q <= ~pair_q;
                            if (!pair_q) begin
                                first_q <= sample_bit;
                            end
                        end
`endif
                        if (take_bit) begin
                            if (bit_ctr_q == LAST_BIT) begin
                                data_q    <= shift_d;
                                valid_q   <= 1'b1;
                                bit_ctr_q <= '0;
                                shift_q   <= shift_d;
                                state_q   <= ST_FULL;
                            end else begin
                                shift_q   <= shift_d;
                                bit_ctr_q <= bit_ctr_q + BIT_W'(1);
                            end
                        end
                    end
                end

                ST_FULL: begin
                    if (entropy_ack) begin
                        valid_q      <= 1'b0;
                        sample_ctr_q <= '0;
                        shift_q      <= '0;
`ifdef ROSC_VN_DEBIAS_EN
                        pair_q       <= 1'b0;
`endif
                        state_q      <= enable ? ST_COLLECT : ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign entropy_data  = data_q;
    assign entropy_valid = valid_q;

endmodule

// File: tb/tb_rosc_entropy_collector.sv
// Testbench for rosc_entropy_collector (NUM_ROSC=4, SAMPLE_CYCLES=4,
// DATA_WIDTH=8). Expected words are queued when a collection is started and
// compared when entropy_valid rises. Inputs are driven and outputs sampled on
// the falling clock edge.
module tb_rosc_entropy_collector;

    localparam int NR = 4;
    localparam int OW = 8;
    localparam int SC = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [NR-1:0] rosc_dout;
    logic [OW-1:0] op_a;
    logic [OW-1:0] op_b;
    logic [DW-1:0] entropy_data;
    logic          entropy_valid;
    logic          entropy_ack;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_q[$];
    logic          valid_prev = 1'b0;

    rosc_entropy_collector #(
        .NUM_ROSC      (NR),
        .OP_WIDTH      (OW),
        .SAMPLE_CYCLES (SC),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .rosc_dout     (rosc_dout),
        .op_a          (op_a),
        .op_b          (op_b),
        .entropy_data  (entropy_data),
        .entropy_valid (entropy_valid),
        .entropy_ack   (entropy_ack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard: compare the data word on each rising edge of valid.
    always @(negedge clk) begin
        if (entropy_valid && !valid_prev) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_word", 32'(exp_q.size()), 32'd1);
            end else begin
                check_val("word_data", 32'(entropy_data), 32'(exp_q.pop_front()));
            end
        end
        valid_prev = entropy_valid;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge: present the first sample value and raise enable.
    // Returns at the negedge after the IDLE->COLLECT edge.
    task automatic start_collect(input logic [NR-1:0] v0);
        rosc_dout = v0;
        enable    = 1'b1;
        tick();
    endtask

    // Starting at the negedge after the COLLECT entry edge, waits for valid.
    // Sample k uses va for even k, vb for odd k; each value is held for one
    // full sample period so it is stable across the synchronizer capture.
    // n = number of edges from COLLECT entry to valid.
    task automatic wait_word(input logic [NR-1:0] va, input logic [NR-1:0] vb,
                             input int limit, output int n);
        n = 0;
        while (n < limit) begin
            tick();
            n++;
            if (entropy_valid) break;
            if ((n % SC) == 0) begin
                rosc_dout = (((n / SC) % 2) == 0) ? va : vb;
            end
        end
        if (!entropy_valid) begin
            check_val("word_timeout", 32'(entropy_valid), 32'd1);
        end
    endtask

    task automatic ack_and_stop();
        entropy_ack = 1'b1;
        enable      = 1'b0;
        tick();
        entropy_ack = 1'b0;
        check_val("ack_clears_valid", 32'(entropy_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;

        reset       = 1'b1;
        enable      = 1'b0;
        entropy_ack = 1'b0;
        rosc_dout   = '0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check_val("rst_valid", 32'(entropy_valid), 32'd0);
        check_val("rst_data",  32'(entropy_data),  32'h00);
        check_val("rst_op_a",  32'(op_a),          32'hAA);
        check_val("rst_op_b",  32'(op_b),          32'h55);

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (entropy_valid) bad++;
        end
        check_val("idle_no_valid", 32'(bad), 32'd0);

`ifndef ROSC_VN_DEBIAS_EN
        // Constant odd-parity input: every sample is 1.
        exp_q.push_back(8'hFF);
        start_collect(4'b0001);
        wait_word(4'b0001, 4'b0001, 200, n);
        check_val("latency_ones", 32'(n), 32'd32);
        ack_and_stop();

        // Constant even-parity input: every sample is 0.
        tick();
        exp_q.push_back(8'h00);
        start_collect(4'b0011);
        wait_word(4'b0011, 4'b0011, 200, n);
        check_val("latency_zeros", 32'(n), 32'd32);
        ack_and_stop();

        // Alternating samples 1,0,1,0,... -> 0xAA, then ack on first valid cycle.
        tick();
        exp_q.push_back(8'hAA);
        start_collect(4'b0001);
        wait_word(4'b0001, 4'b0000, 200, n);
        check_val("latency_alt", 32'(n), 32'd32);
        exp_q.push_back(8'hFF);
        rosc_dout   = 4'b0001;
        entropy_ack = 1'b1;
        tick();
        entropy_ack = 1'b0;
        check_val("valid_low_after_ack", 32'(entropy_valid), 32'd0);
        wait_word(4'b0001, 4'b0001, 200, n);
        check_val("valid_to_next_valid", 32'(n + 1), 32'd33);

        // Backpressure: word held while inputs change underneath.
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            rosc_dout = 4'($urandom_range(15, 0));
            tick();
            if (!entropy_valid || entropy_data !== 8'hFF) bad++;
        end
        check_val("hold_under_backpressure", 32'(bad), 32'd0);
        ack_and_stop();

        // Ack while not valid is ignored.
        entropy_ack = 1'b1;
        tick();
        entropy_ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (entropy_valid) bad++;
        end
        check_val("stray_ack_ignored", 32'(bad), 32'd0);

        // Drop enable after 5 zero samples; the partial word must not leak.
        start_collect(4'b0011);
        repeat (5 * SC + 1) tick();
        enable = 1'b0;
        tick();
        rosc_dout = 4'b0001;
        repeat (3) tick();
        check_val("abort_no_valid", 32'(entropy_valid), 32'd0);
        exp_q.push_back(8'hFF);
        start_collect(4'b0001);
        wait_word(4'b0001, 4'b0001, 200, n);
        check_val("latency_after_abort", 32'(n), 32'd32);
        ack_and_stop();
        tick();

        exp_q.push_back(8'hFF);
        start_collect(4'b0001);
        wait_word(4'b0001, 4'b0001, 200, n);
`else
        // Stuck input: every pair is equal, nothing is ever shifted in.
        start_collect(4'b0001);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (entropy_valid) bad++;
        end
        check_val("vn_stuck_no_valid", 32'(bad), 32'd0);
        enable = 1'b0;
        repeat (3) tick();

        // Pairs (1,0) each yield a 1.
        exp_q.push_back(8'hFF);
        start_collect(4'b0001);
        wait_word(4'b0001, 4'b0000, 300, n);
        check_val("vn_latency", 32'(n), 32'd64);
`endif

        // Reset while FULL drops the word on that edge.
        reset = 1'b1;
        tick();
        check_val("reset_full_valid", 32'(entropy_valid), 32'd0);
        check_val("reset_full_data",  32'(entropy_data),  32'h00);
        reset  = 1'b0;
        enable = 1'b0;
        tick();

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
